ps2_keyboard_state: RTL and testbench

Upstream neighbour of the user control stage. Receives raw PS/2 keyboard clock/data, deframes scan-code set 2 bytes and tracks make/break sequences. Maintains an 8-bit held-key bitmap driven directly into user control's kb_in. Debug byte/error strobes are exported for the seven-segment display.

---
 rtl/ps2_keyboard_state_pkg.sv | 70 +++++++
 rtl/ps2_keyboard_state_ps2_rx.sv | 111 +++++++++++
 rtl/ps2_keyboard_state.sv | 110 +++++++++++
 tb/tb_ps2_keyboard_state.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_state_pkg.sv
// ps2_keyboard_state_pkg
// Shared definitions for the PS/2 keyboard front end and user control:
// held-key bitmap indices, scan-code set 2 constants, the key lookup helper
// and the receiver state type.
package ps2_keyboard_state_pkg;

  // Bit positions in the held-key bitmap (consumed by user control's kb_in)
  localparam int unsigned KB_FORWARD     = 7;
  localparam int unsigned KB_BACKWARD    = 6;
  localparam int unsigned KB_TURN_LEFT   = 5;
  localparam int unsigned KB_TURN_RIGHT  = 4;
  localparam int unsigned KB_TRANS_UP    = 3;
  localparam int unsigned KB_TRANS_DOWN  = 2;
  localparam int unsigned KB_TRANS_LEFT  = 1;
  localparam int unsigned KB_TRANS_RIGHT = 0;

  // Protocol prefixes and self-test results
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_BAT      = 8'hAA;
  localparam logic [7:0] SC_BAT_FAIL = 8'hFC;

  // Key codes; the first four are plain, the arrows follow an E0 prefix
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_lookup_t;

  // Map (ext, code) to a bitmap index; a code seen with the wrong ext flag misses
  function automatic key_lookup_t key_lookup(input logic ext, input logic [7:0] code);
    key_lookup_t r;
    r.hit = 1'b1;
    r.idx = 3'd0;
    if (!ext) begin
      case (code)
        SC_W:    r.idx = 3'(KB_FORWARD);
        SC_S:    r.idx = 3'(KB_BACKWARD);
        SC_A:    r.idx = 3'(KB_TURN_LEFT);
        SC_D:    r.idx = 3'(KB_TURN_RIGHT);
        default: r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP:    r.idx = 3'(KB_TRANS_UP);
        SC_DOWN:  r.idx = 3'(KB_TRANS_DOWN);
        SC_LEFT:  r.idx = 3'(KB_TRANS_LEFT);
        SC_RIGHT: r.idx = 3'(KB_TRANS_RIGHT);
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_keyboard_state_ps2_rx.sv
// ps2_rx
// PS/2 device-to-host frame receiver: input synchronizers, falling-edge
// detect, start/8 data/odd parity/stop deframing and an inter-edge timeout.
// Ports:
//   clk_i, rst_i      system clock, async active-high reset
//   ps2_clk_i         raw PS/2 clock pin
//   ps2_data_i        raw PS/2 data pin
//   rx_valid_o        one-cycle strobe, rx_byte_o holds a good byte
//   rx_byte_o         received byte
//   rx_err_o          one-cycle strobe on parity, stop-bit or timeout error
module ps2_rx
  import ps2_keyboard_state_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_err_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  rx_state_t  state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       parity_q;
  logic [TW-1:0] tmo_q;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  // Synchronizers reset to the idle-high line level so release makes no edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
    end
  end

  // Frame FSM with timeout; the counter only runs while a frame is open
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      rx_valid_o <= 1'b0;
      rx_byte_o  <= 8'd0;
      rx_err_o   <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;
      if (state_q == RX_IDLE) begin
        tmo_q <= '0;
        if (fall && !data_s) begin
          state_q   <= RX_DATA;
          bit_cnt_q <= 3'd0;
        end
      end else if (fall) begin
        tmo_q <= '0;
        case (state_q)
          RX_DATA: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_q <= data_s;
            state_q  <= RX_STOP;
          end
          default: begin
            // Odd parity across the 8 data bits plus the parity bit
            if (data_s && (^{shift_q, parity_q})) begin
              rx_valid_o <= 1'b1;
              rx_byte_o  <= shift_q;
            end else begin
              rx_err_o <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
        endcase
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q  <= RX_IDLE;
        rx_err_o <= 1'b1;
        tmo_q    <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_state.sv
// ps2_keyboard_state
// PS/2 keyboard front end: receives scan-code set 2 bytes, tracks E0/F0
// prefixes and maintains the held-key bitmap for user control.
// Ports:
//   clk_in, rst_in    system clock, async active-high reset
//   ps2_clk_in        raw PS/2 clock pin (idles high)
//   ps2_data_in       raw PS/2 data pin (idles high)
//   kb_out            held-key bitmap, 1 while held
//   byte_valid_out    one-cycle strobe per good frame
//   byte_out          last good byte
//   err_out           one-cycle strobe per bad or timed-out frame
module ps2_keyboard_state
  import ps2_keyboard_state_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] kb_out,
  output logic       byte_valid_out,
  output logic [7:0] byte_out,
  output logic       err_out
);

  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_err;

  logic [7:0]  kb_q, kb_d;
  logic [7:0]  byte_q, byte_d;
  logic        bv_q, bv_d;
  logic        err_q, err_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  key_lookup_t lk;

  ps2_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .ps2_clk_i (ps2_clk_in),
    .ps2_data_i(ps2_data_in),
    .rx_valid_o(rx_valid),
    .rx_byte_o (rx_byte),
    .rx_err_o  (rx_err)
  );

  assign lk = key_lookup(ext_q, rx_byte);

  // Prefix tracking and bitmap update; any error drops pending prefixes
  always_comb begin
    kb_d   = kb_q;
    byte_d = byte_q;
    bv_d   = 1'b0;
    err_d  = 1'b0;
    ext_d  = ext_q;
    brk_d  = brk_q;
    if (rx_err) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      bv_d   = 1'b1;
      byte_d = rx_byte;
      case (rx_byte)
        SC_EXT:   ext_d = 1'b1;
        SC_BREAK: brk_d = 1'b1;
        SC_BAT, SC_BAT_FAIL: begin
          kb_d  = 8'd0;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          if (lk.hit) kb_d[lk.idx] = ~brk_q;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      kb_q   <= 8'd0;
      byte_q <= 8'd0;
      bv_q   <= 1'b0;
      err_q  <= 1'b0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      kb_q   <= kb_d;
      byte_q <= byte_d;
      bv_q   <= bv_d;
      err_q  <= err_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
    end
  end

  assign kb_out         = kb_q;
  assign byte_out       = byte_q;
  assign byte_valid_out = bv_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_ps2_keyboard_state.sv
// tb_ps2_keyboard_state
// Scoreboard bench: each frame sent pushes its expected strobe/byte/bitmap;
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_ps2_keyboard_state;

  localparam int unsigned TMO = 200;
  localparam int unsigned H   = 20;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic [7:0] kb_out;
  logic       byte_valid_out;
  logic [7:0] byte_out;
  logic       err_out;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    logic [7:0] kb;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   errors = 0;
  int   checks = 0;

  ps2_keyboard_state #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .ps2_clk_in    (ps2_clk_in),
    .ps2_data_in   (ps2_data_in),
    .kb_out        (kb_out),
    .byte_valid_out(byte_valid_out),
    .byte_out      (byte_out),
    .err_out       (err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_err, input logic [7:0] b, input logic [7:0] kb);
    exp_t e;
    e.is_err = is_err;
    e.b      = b;
    e.kb     = kb;
    q.push_back(e);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data_in = v;
    wait_clk(H);
    ps2_clk_in = 1'b0;
    wait_clk(H);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                      input logic [7:0] exp_kb);
    push_exp(bad_par | bad_stop, b, exp_kb);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data_in = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic key(input logic [7:0] b, input logic [7:0] exp_kb);
    send(b, 1'b0, 1'b0, exp_kb);
  endtask

  // Start bit plus n data bits, then the line is left idle
  task automatic partial(input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(i[0]);
    ps2_data_in = 1'b1;
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && (byte_valid_out || err_out)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: bv=%b err=%b byte=%h kb=%h",
                 byte_valid_out, err_out, byte_out, kb_out);
      end else begin
        m = q.pop_front();
        if (byte_valid_out !== !m.is_err || err_out !== m.is_err ||
            (byte_valid_out && byte_out !== m.b) || kb_out !== m.kb) begin
          errors++;
          $display("FAIL scoreboard: got bv=%b err=%b byte=%h kb=%h expected bv=%b err=%b byte=%h kb=%h",
                   byte_valid_out, err_out, byte_out, kb_out,
                   !m.is_err, m.is_err, m.b, m.kb);
        end
      end
    end
  end

  initial begin
    rst_in      = 1'b1;
    ps2_clk_in  = 1'b1;
    ps2_data_in = 1'b1;
    wait_clk(3);
    check("reset_kb", kb_out, 8'h00);
    check("reset_byte", byte_out, 8'h00);
    check("reset_strobes", {6'd0, byte_valid_out, err_out}, 8'h00);
    rst_in = 1'b0;
    wait_clk(10);

    // W make/break
    key(8'h1D, 8'h80);
    check("byte_held", byte_out, 8'h1D);
    key(8'hF0, 8'h80);
    key(8'h1D, 8'h00);

    // Up arrow plus W, release up, typematic W
    key(8'hE0, 8'h00);
    key(8'h75, 8'h08);
    key(8'h1D, 8'h88);
    key(8'hE0, 8'h88);
    key(8'hF0, 8'h88);
    key(8'h75, 8'h80);
    key(8'h1D, 8'h80);
    key(8'h1D, 8'h80);
    key(8'h1D, 8'h80);

    // Parity error then good A
    send(8'h1C, 1'b1, 1'b0, 8'h80);
    check("byte_after_err", byte_out, 8'h1D);
    key(8'h1C, 8'hA0);

    // Error drops the E0 prefix, so 0x75 is unmapped
    key(8'hE0, 8'hA0);
    send(8'h75, 1'b0, 1'b1, 8'hA0);
    key(8'h75, 8'hA0);

    // Timeout on a partial frame, then good D
    push_exp(1'b1, 8'h00, 8'hA0);
    partial(4);
    wait_clk(TMO + 100);
    key(8'h23, 8'hB0);

    // Release everything, ext+W is unmapped
    key(8'hF0, 8'hB0);
    key(8'h1D, 8'h30);
    key(8'hF0, 8'h30);
    key(8'h1C, 8'h10);
    key(8'hF0, 8'h10);
    key(8'h23, 8'h00);
    key(8'hE0, 8'h00);
    key(8'h1D, 8'h00);

    // Hold W and up, async reset mid-frame
    key(8'h1D, 8'h80);
    key(8'hE0, 8'h80);
    key(8'h75, 8'h88);
    partial(3);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    #1;
    check("async_reset_kb", kb_out, 8'h00);
    check("async_reset_byte", byte_out, 8'h00);
    wait_clk(3);
    rst_in = 1'b0;
    wait_clk(TMO + 100);

    // BAT clears held keys; ext+A unmapped
    key(8'h1D, 8'h80);
    key(8'hE0, 8'h80);
    key(8'h75, 8'h88);
    key(8'hE0, 8'h88);
    key(8'h1C, 8'h88);
    key(8'hAA, 8'h00);
    check("bat_kb", kb_out, 8'h00);

    wait_clk(50);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d outstanding expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
